// File: rtl/calc_pkg.sv
// Shared types for the calculator operand-entry path: operator codes, entry FSM states and
// the default datapath width.
package calc_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef logic [2:0] op_t;

  localparam op_t OpNone = 3'b000;
  localparam op_t OpAdd  = 3'b001;
  localparam op_t OpSub  = 3'b010;
  localparam op_t OpMul  = 3'b011;
  localparam op_t OpDiv  = 3'b100;
  localparam op_t OpClr  = 3'b111;

  typedef enum logic [2:0] {
    EnterA,
    EnterB,
    Req,
    Wait,
    Show
  } entry_state_t;

  function automatic logic is_arith(op_t op);
    return (op == OpAdd) || (op == OpSub) || (op == OpMul) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Signed decimal digit accumulator: magnitude, sign and digit count with range-checked
// digit insertion and a two's-complement view of the value.
module dec_accumulator import calc_pkg::*; #(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              set_neg,
  input  logic              digit_en,
  input  logic [3:0]        digit,
  output logic              reject,
  output logic              empty,
  output logic              neg,
  output logic [DATA_W-1:0] value
);

  localparam int unsigned AccW  = DATA_W + 1;
  localparam int unsigned ProdW = AccW + 4;
  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);

  localparam logic [ProdW-1:0] NegLimit = ProdW'(1) << (DATA_W - 1);
  localparam logic [ProdW-1:0] PosLimit = NegLimit - ProdW'(1);

  logic [AccW-1:0]  acc_q, acc_d, base_acc, neg_acc;
  logic             neg_q, neg_d, base_neg;
  logic [CntW-1:0]  cnt_q, cnt_d, base_cnt;
  logic [ProdW-1:0] new_val;

  // Clear and a digit may arrive together: the digit then starts a fresh number.
  always_comb begin
    base_acc = clear ? '0 : acc_q;
    base_neg = clear ? 1'b0 : neg_q;
    base_cnt = clear ? '0 : cnt_q;
    new_val  = ProdW'(base_acc) * ProdW'(10) + ProdW'(digit);
    reject   = digit_en && ((base_cnt == CntW'(MAX_DIGITS)) ||
                            (new_val > (base_neg ? NegLimit : PosLimit)));
    acc_d    = base_acc;
    neg_d    = base_neg | set_neg;
    cnt_d    = base_cnt;
    if (digit_en && !reject) begin
      acc_d = new_val[AccW-1:0];
      cnt_d = base_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
    end
  end

  assign neg_acc = -acc_q;
  assign value   = neg_q ? neg_acc[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign empty   = (cnt_q == '0);
  assign neg     = neg_q;

endmodule

// File: rtl/operand_entry.sv
// Key-driven operand/operator entry feeding the ALU and display. Define RESULT_CHAIN_EN to let
// an operator pressed while a result is shown reuse that result as operand A.
module operand_entry import calc_pkg::*; #(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              KeyRdy,
  output logic              KeyRd,
  input  logic [3:0]        keypad_input,
  input  logic [2:0]        operator_input,
  input  logic              equal_input,
  output logic              calc_valid,
  input  logic              calc_ready,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [2:0]        calc_op,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] calc_result,
  input  logic              result_err,
  output logic [DATA_W-1:0] display_value,
  output logic              err_flag,
  output logic              entry_err
);

  entry_state_t      state_q, state_d;
  logic              armed_q, key_rd_q, pend_q;
  op_t               op_key_q;
  logic              eq_key_q;
  logic [3:0]        dig_key_q;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, hold_q, hold_d;
  op_t               cop_q, cop_d;
  logic              err_q, err_d, entry_err_q;

  logic              fetch_ok, key_take, is_op, is_eq, is_dig;
  logic              acc_clear, acc_set_neg, acc_digit_en;
  logic              acc_reject, acc_empty, acc_neg;
  logic [DATA_W-1:0] acc_value;

  dec_accumulator #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk      (clk),
    .rst      (RST),
    .clear    (acc_clear),
    .set_neg  (acc_set_neg),
    .digit_en (acc_digit_en),
    .digit    (dig_key_q),
    .reject   (acc_reject),
    .empty    (acc_empty),
    .neg      (acc_neg),
    .value    (acc_value)
  );

  // No new fetch while a captured key is still waiting to be processed.
  assign fetch_ok = ((state_q == EnterA) || (state_q == EnterB) || (state_q == Show)) && !pend_q;
  assign key_take = fetch_ok && KeyRdy && armed_q;
  assign is_op    = pend_q && (op_key_q != OpNone);
  assign is_eq    = pend_q && !is_op && eq_key_q;
  assign is_dig   = pend_q && !is_op && !eq_key_q && (dig_key_q <= 4'd9);

  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cop_d        = cop_q;
    hold_d       = hold_q;
    err_d        = err_q;
    acc_clear    = 1'b0;
    acc_set_neg  = 1'b0;
    acc_digit_en = 1'b0;
    if (is_op && (op_key_q == OpClr)) begin
      state_d   = EnterA;
      opa_d     = '0;
      opb_d     = '0;
      cop_d     = OpNone;
      hold_d    = '0;
      err_d     = 1'b0;
      acc_clear = 1'b1;
    end else begin
      unique case (state_q)
        EnterA: begin
          if (is_op && is_arith(op_key_q)) begin
            if ((op_key_q == OpSub) && acc_empty && !acc_neg) begin
              acc_set_neg = 1'b1;
            end else if (!acc_empty) begin
              opa_d     = acc_value;
              cop_d     = op_key_q;
              acc_clear = 1'b1;
              state_d   = EnterB;
            end
          end else if (is_dig) begin
            acc_digit_en = 1'b1;
          end
        end
        EnterB: begin
          if (is_op && is_arith(op_key_q)) begin
            if (acc_empty) begin
              if ((op_key_q == OpSub) && !acc_neg) acc_set_neg = 1'b1;
              else                                 cop_d       = op_key_q;
            end
          end else if (is_eq && !acc_empty) begin
            opb_d     = acc_value;
            hold_d    = acc_value;
            acc_clear = 1'b1;
            state_d   = Req;
          end else if (is_dig) begin
            acc_digit_en = 1'b1;
          end
        end
        Req: begin
          if (calc_ready) state_d = Wait;
        end
        Wait: begin
          if (result_valid) begin
            hold_d  = calc_result;
            opa_d   = calc_result;
            err_d   = result_err;
            state_d = Show;
          end
        end
        Show: begin
          if (is_dig) begin
            err_d        = 1'b0;
            acc_clear    = 1'b1;
            acc_digit_en = 1'b1;
            state_d      = EnterA;
          end
`ifdef RESULT_CHAIN_EN
          else if (is_op && is_arith(op_key_q) && !err_q) begin
            cop_d   = op_key_q;
            state_d = EnterB;
          end
`endif
        end
        default: state_d = EnterA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= EnterA;
      armed_q     <= 1'b1;
      key_rd_q    <= 1'b0;
      pend_q      <= 1'b0;
      op_key_q    <= OpNone;
      eq_key_q    <= 1'b0;
      dig_key_q   <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cop_q       <= OpNone;
      hold_q      <= '0;
      err_q       <= 1'b0;
      entry_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_rd_q    <= key_take;
      pend_q      <= key_take;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cop_q       <= cop_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      entry_err_q <= acc_reject;
      if (key_take) begin
        op_key_q  <= operator_input;
        eq_key_q  <= equal_input;
        dig_key_q <= keypad_input;
        armed_q   <= 1'b0;
      end else if (!KeyRdy) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign KeyRd         = key_rd_q;
  assign calc_valid    = (state_q == Req);
  assign operand_a     = opa_q;
  assign operand_b     = opb_q;
  assign calc_op       = cop_q;
  assign display_value = ((state_q == EnterA) || (state_q == EnterB)) ? acc_value : hold_q;
  assign err_flag      = err_q;
  assign entry_err     = entry_err_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios followed by random key sequences,
// checked against a value-level calculator model.
module tb_operand_entry;

  localparam int MAXD = 5;
  localparam int S_A = 0, S_B = 1, S_REQ = 2, S_WAIT = 3, S_SHOW = 4;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        KeyRdy = 1'b0;
  logic        KeyRd;
  logic [3:0]  keypad_input = '0;
  logic [2:0]  operator_input = '0;
  logic        equal_input = 1'b0;
  logic        calc_valid;
  logic        calc_ready = 1'b0;
  logic [15:0] operand_a, operand_b, display_value;
  logic [2:0]  calc_op;
  logic        result_valid = 1'b0;
  logic [15:0] calc_result = '0;
  logic        result_err = 1'b0;
  logic        err_flag, entry_err;

  operand_entry dut (
    .clk            (clk),
    .RST            (RST),
    .KeyRdy         (KeyRdy),
    .KeyRd          (KeyRd),
    .keypad_input   (keypad_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .calc_valid     (calc_valid),
    .calc_ready     (calc_ready),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .calc_op        (calc_op),
    .result_valid   (result_valid),
    .calc_result    (calc_result),
    .result_err     (result_err),
    .display_value  (display_value),
    .err_flag       (err_flag),
    .entry_err      (entry_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, kr_cnt = 0;
  always @(posedge clk) if (KeyRd === 1'b1) kr_cnt <= kr_cnt + 1;

  // Calculator model: integer values, no bit-level state.
  int m_state, m_acc, m_cnt, m_a, m_b, m_op, m_hold;
  bit m_neg, m_err;

  function automatic int m_sval();
    return m_neg ? -m_acc : m_acc;
  endfunction

  function automatic int m_disp();
    return (m_state == S_A || m_state == S_B) ? m_sval() : m_hold;
  endfunction

  task automatic acc_zero();
    m_acc = 0; m_cnt = 0; m_neg = 0;
  endtask

  task automatic model_clear();
    acc_zero();
    m_a = 0; m_b = 0; m_op = 0; m_hold = 0; m_err = 0; m_state = S_A;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_outputs();
    chk("display", display_value, 16'(m_disp()));
    chk("operand_a", operand_a, 16'(m_a));
    chk("operand_b", operand_b, 16'(m_b));
    chk("calc_op", 16'(calc_op), 16'(m_op));
    chk("calc_valid", 16'(calc_valid), 16'(m_state == S_REQ));
    chk("err_flag", 16'(err_flag), 16'(m_err));
  endtask

  task automatic model_key(input logic [2:0] op, input logic eq, input logic [3:0] dig,
                           output bit rej);
    int nv;
    rej = 0;
    if (op != 0) begin
      if (op == 7) model_clear();
      else if (op >= 1 && op <= 4) begin
        if (m_state == S_A) begin
          if (op == 2 && m_cnt == 0 && !m_neg) m_neg = 1;
          else if (m_cnt > 0) begin
            m_a = m_sval(); m_op = int'(op); acc_zero(); m_state = S_B;
          end
        end else if (m_state == S_B) begin
          if (m_cnt == 0) begin
            if (op == 2 && !m_neg) m_neg = 1;
            else m_op = int'(op);
          end
        end else if (m_state == S_SHOW) begin
`ifdef RESULT_CHAIN_EN
          if (!m_err) begin m_op = int'(op); m_state = S_B; end
`endif
        end
      end
    end else if (eq) begin
      if (m_state == S_B && m_cnt > 0) begin
        m_b = m_sval(); m_hold = m_b; acc_zero(); m_state = S_REQ;
      end
    end else if (dig <= 9) begin
      if (m_state == S_SHOW) begin m_err = 0; acc_zero(); m_state = S_A; end
      nv = m_acc * 10 + int'(dig);
      if (m_cnt >= MAXD || nv > (m_neg ? 32768 : 32767)) rej = 1;
      else begin m_acc = nv; m_cnt++; end
    end
  endtask

  // One full key press: KeyRdy high until acknowledged plus a cycle, then released.
  task automatic press(input logic [2:0] op, input logic eq, input logic [3:0] dig);
    int n, k0;
    logic e1, e2;
    bit rej;
    k0 = kr_cnt;
    operator_input = op; equal_input = eq; keypad_input = dig; KeyRdy = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (KeyRd !== 1'b1 && n < 10);
    chk("keyrd_seen", 16'(KeyRd), 16'd1);
    @(negedge clk); e1 = entry_err;
    @(negedge clk); e2 = entry_err;
    KeyRdy = 1'b0;
    operator_input = 3'($urandom); equal_input = 1'($urandom); keypad_input = 4'($urandom);
    @(negedge clk); @(negedge clk);
    model_key(op, eq, dig, rej);
    chk("entry_err", 16'(e1), 16'(rej));
    chk("entry_err_pulse", 16'(e2), 16'd0);
    chk("keyrd_count", 16'(kr_cnt - k0), 16'd1);
    chk_outputs();
  endtask

  task automatic digits(input int v);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) press(3'd0, 1'b0, 4'(s[i] - "0"));
  endtask

  // ALU side: accept after acc_dly cycles, answer after res_dly cycles.
  task automatic alu(input int acc_dly, input int res_dly);
    int r;
    bit e;
    logic signed [15:0] r16;
    for (int i = 0; i < acc_dly; i++) begin
      @(negedge clk);
      chk("valid_hold", 16'(calc_valid), 16'd1);
      chk("op_stable", 16'(calc_op), 16'(m_op));
    end
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    m_state = S_WAIT;
    chk("valid_drop", 16'(calc_valid), 16'd0);
    e = 0;
    case (m_op)
      1: r = m_a + m_b;
      2: r = m_a - m_b;
      3: r = m_a * m_b;
      default: begin
        if (m_b == 0) begin r = 0; e = 1; end
        else r = m_a / m_b;
      end
    endcase
    if (r > 32767 || r < -32768) e = 1;
    r16 = 16'(r);
    for (int i = 0; i < res_dly; i++) begin
      @(negedge clk);
      chk("wait_display", display_value, 16'(m_hold));
    end
    calc_result = r16; result_err = e; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0; calc_result = 16'($urandom); result_err = 1'($urandom);
    m_a = int'(r16); m_hold = int'(r16); m_err = e; m_state = S_SHOW;
    chk_outputs();
  endtask

  initial begin
    int k0, r, o;
    model_clear();
    repeat (3) @(negedge clk);
    RST = 1'b0;
    chk("rst_keyrd", 16'(KeyRd), 16'd0);
    chk("rst_entry_err", 16'(entry_err), 16'd0);
    chk_outputs();

    // 12 + 3, then chained or ignored operator on the shown result.
    digits(12); press(3'd1, 1'b0, 4'd0); digits(3); press(3'd0, 1'b1, 4'd0);
    chk("tp_a12", operand_a, 16'd12);
    chk("tp_b3", operand_b, 16'd3);
    chk("tp_op_add", 16'(calc_op), 16'd1);
    alu(3, 2);
    chk("tp_disp15", display_value, 16'd15);
    press(3'd1, 1'b0, 4'd0);
    chk("show_after_op", display_value, 16'd15);
    digits(1); press(3'd0, 1'b1, 4'd0);
`ifdef RESULT_CHAIN_EN
    chk("chain_a", operand_a, 16'd15);
    chk("chain_b", operand_b, 16'd1);
    if (m_state == S_REQ) alu(0, 0);
`else
    chk("nochain_disp", display_value, 16'd1);
    chk("nochain_valid", 16'(calc_valid), 16'd0);
`endif
    press(3'd7, 1'b0, 4'd0);

    // Negative operands and operator replacement priority.
    press(3'd2, 1'b0, 4'd0); digits(5); press(3'd3, 1'b0, 4'd0);
    press(3'd2, 1'b0, 4'd0); digits(7);
    // No fetch while a request is outstanding.
    press(3'd0, 1'b1, 4'd0);
    chk("neg_a", operand_a, 16'hFFFB);
    chk("neg_b", operand_b, 16'hFFF9);
    chk("mul_op", 16'(calc_op), 16'd3);
    k0 = kr_cnt;
    keypad_input = 4'd3; KeyRdy = 1'b1;
    repeat (4) @(negedge clk);
    KeyRdy = 1'b0;
    @(negedge clk);
    chk("req_no_fetch", 16'(kr_cnt - k0), 16'd0);
    alu(1, 1);
    chk("disp35", display_value, 16'd35);
    press(3'd7, 1'b0, 4'd0);

    // Range limits.
    digits(32768);
    chk("pos_limit", display_value, 16'd3276);
    digits(7);
    chk("pos_max", display_value, 16'd32767);
    press(3'd7, 1'b0, 4'd0);
    press(3'd2, 1'b0, 4'd0); digits(32768);
    chk("neg_min", display_value, 16'h8000);
    digits(1);
    press(3'd7, 1'b0, 4'd0);

    // Held KeyRdy yields one acknowledge per press.
    k0 = kr_cnt;
    operator_input = 3'd0; equal_input = 1'b0; keypad_input = 4'd1; KeyRdy = 1'b1;
    repeat (6) @(negedge clk);
    KeyRdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_one_pulse", 16'(kr_cnt - k0), 16'd1);
    KeyRdy = 1'b1;
    repeat (6) @(negedge clk);
    KeyRdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("second_pulse", 16'(kr_cnt - k0), 16'd2);
    chk("hold_disp11", display_value, 16'd11);
    press(3'd7, 1'b0, 4'd0);

    // CLR mid-entry.
    digits(4); press(3'd1, 1'b0, 4'd0); digits(9); press(3'd7, 1'b0, 4'd0);
    chk("clr_a", operand_a, 16'd0);
    chk("clr_disp", display_value, 16'd0);
    chk("clr_op", 16'(calc_op), 16'd0);

    // Reset while waiting for the ALU drops the late result.
    digits(1); press(3'd1, 1'b0, 4'd0); digits(2); press(3'd0, 1'b1, 4'd0);
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    model_clear();
    calc_result = 16'd99; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    chk("late_result_disp", display_value, 16'd0);
    chk_outputs();
    digits(5);

    // Random key streams.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 50) press(3'd0, 1'b0, 4'($urandom_range(0, 9)));
      else if (r < 55) press(3'd0, 1'b0, 4'($urandom_range(10, 15)));
      else if (r < 85) begin
        o = $urandom_range(1, 20);
        press((o <= 16) ? 3'((o - 1) % 4 + 1) : ((o <= 18) ? 3'(o - 12) : 3'd7),
              1'($urandom), 4'($urandom));
      end else press(3'd0, 1'b1, 4'($urandom));
      if (m_state == S_REQ) alu($urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
